counter_timer_multi: RTL and testbench
======================================

COUNTER_TIMER_MULTI -- requirements
Module: counter_timer_multi

Interface
REQ-001 SHALL have parameter NCH, default 2, giving the number of independent timer channels (1..8).
REQ-002 SHALL have parameter WIDTH, default 32, giving the counter, register and data width.
REQ-003 SHALL have port clkin, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port reg_addr, input, clog2(NCH)+2 bits: channel index in the upper bits, register select in bits [1:0].
REQ-006 SHALL have port reg_we, input, 1 bit: write strobe, one word per cycle.
REQ-007 SHALL have port reg_wdata, input, WIDTH bits: write data.
REQ-008 SHALL have port reg_rdata, output, WIDTH bits: read data, registered.
REQ-009 SHALL have port event_out, output, NCH bits: one-cycle terminal-count pulse per channel.
REQ-010 SHALL have port irq_out, output, NCH bits: sticky interrupt per channel.

Function
REQ-011 Register select values SHALL be: 0 = CFG, 1 = VALUE, 2 = DATA, 3 = STATUS.
REQ-012 CFG bits SHALL be: [0] enable, [1] continuous (0 = one-shot), [2] up (0 = down), [3] chain, [4] irq_en; other bits read as 0.
REQ-013 reg_rdata SHALL present the addressed register one cycle after reg_addr; STATUS reads {irq pending in bit 0, 0 elsewhere}.
REQ-014 A channel SHALL count on a cycle only when enable=1 and its count condition holds: always if chain=0; if chain=1, only on a cycle where event_out of channel i-1 is 1.
REQ-015 chain SHALL be ignored for channel 0, which always counts when enabled.
REQ-016 In down mode, a counting cycle with VALUE != 0 SHALL decrement VALUE; with VALUE == 0 it SHALL fire the event and then either reload DATA (continuous) or hold 0 and stop counting (one-shot).
REQ-017 In up mode, a counting cycle with VALUE != DATA SHALL increment VALUE modulo 2^WIDTH; with VALUE == DATA it SHALL fire the event and then either load 0 (continuous) or hold DATA and stop counting (one-shot).
REQ-018 A one-shot channel SHALL keep enable=1 after stopping; the next write to VALUE restarts counting.
REQ-019 event_out[i] SHALL pulse on the cycle after the terminal counting cycle, so chained channel i+1 lags by exactly one cycle per stage.
REQ-020 An event with irq_en=1 SHALL set the irq pending bit; irq_out[i] = pending AND irq_en.
REQ-021 Writing 1 to STATUS bit 0 SHALL clear pending; if an event occurs on the same cycle, set SHALL win.
REQ-022 A VALUE write on the same cycle as a count SHALL win; counting resumes from the written value on the next cycle.
REQ-023 DATA writes SHALL take effect on the next terminal comparison or reload without disturbing VALUE.
REQ-024 A write to a channel index >= NCH SHALL be ignored and read back as 0.

Reset
REQ-025 While resetn=0 at a clkin edge, all CFG, VALUE, DATA and pending bits, reg_rdata, event_out and irq_out SHALL become 0.
REQ-026 Reset asserted mid-count SHALL abort counting with no event fired; channels remain idle (enable=0) after release.

Structure
REQ-027 The register-select encodings, CFG bit positions and STATUS bit position SHALL live in a shared package counter_timer_pkg.
REQ-028 Per-channel logic SHALL be one sub-module, counter_timer_chan, instantiated NCH times by a generate loop; the top SHALL contain only address decode, the read mux and chain wiring.

Verification
REQ-029 Ch0, down, one-shot, irq_en=1, VALUE=5: event_out[0] pulses exactly once, 6 cycles after enable; VALUE holds 0; irq_out[0]=1 until STATUS is written with 1.
REQ-030 Ch0, up, continuous, DATA=3, VALUE=0: event_out[0] pulses every 4 cycles; VALUE sequence is 0,1,2,3,0.
REQ-031 Ch0 down continuous DATA=2; ch1 chain=1 down one-shot VALUE=1: ch1 decrements only on ch0 events, and event_out[1] fires one cycle after ch0's second event.
REQ-032 VALUE write of 0x12bc on a counting cycle: the next cycle reads 0x12bc, then 0x12bb (down).
REQ-033 STATUS clear on the same cycle as an event: pending stays 1.
REQ-034 resetn=0 mid-count with VALUE=0xdcba7cfb: all registers read 0, no event pulse, and the channel stays idle after release.

Source files
------------

// File: rtl/counter_timer_pkg.sv
// Shared register map and CFG/STATUS bit layout for the multi-channel counter/timer.
// Imported by the channel sub-module and by the top-level address decoder.
package counter_timer_pkg;

  typedef enum logic [1:0] {
    REG_CFG    = 2'd0,
    REG_VALUE  = 2'd1,
    REG_DATA   = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;

  localparam int CFG_EN      = 0;
  localparam int CFG_CONT    = 1;
  localparam int CFG_UP      = 2;
  localparam int CFG_CHAIN   = 3;
  localparam int CFG_IRQ_EN  = 4;
  localparam int CFG_BITS    = 5;
  localparam int STATUS_PEND = 0;

  function automatic int addr_width(input int nch);
    return $clog2(nch) + 2;
  endfunction

endpackage

// File: rtl/counter_timer_chan.sv
// One timer channel: CFG/VALUE/DATA/pending registers, up/down counting with
// one-shot or continuous terminal handling, chained counting and sticky interrupt.
module counter_timer_chan
  import counter_timer_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit CHAIN_OK = 1'b1
) (
  input  logic                clkin,
  input  logic                resetn,
  input  logic                i_we,
  input  logic [1:0]          i_sel,
  input  logic [WIDTH-1:0]    i_wdata,
  input  logic                i_prev_event,
  output logic [CFG_BITS-1:0] o_cfg,
  output logic [WIDTH-1:0]    o_value,
  output logic [WIDTH-1:0]    o_data,
  output logic                o_pending,
  output logic                o_event,
  output logic                o_irq
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [CFG_BITS-1:0] r_cfg;
  logic [WIDTH-1:0]    r_value;
  logic [WIDTH-1:0]    r_data;
  logic                r_pend;
  logic                r_stop;
  logic                r_event;
  logic                r_irq;

  logic [CFG_BITS-1:0] w_cfg_nxt;
  logic [WIDTH-1:0]    w_value_nxt;
  logic [WIDTH-1:0]    w_data_nxt;
  logic                w_pend_nxt;
  logic                w_stop_nxt;
  logic                w_clr;
  logic                w_count;
  logic                w_term;
  logic                w_fire;

  // Channel 0 is built with CHAIN_OK=0 so its chain bit never gates counting.
  assign w_count = r_cfg[CFG_EN] & ~r_stop &
                   (~(CHAIN_OK & r_cfg[CFG_CHAIN]) | i_prev_event);
  assign w_term  = r_cfg[CFG_UP] ? (r_value == r_data) : (r_value == '0);
  assign w_fire  = w_count & w_term;

  // Next-state for all channel registers; a register write overrides counting.
  always_comb begin
    w_cfg_nxt   = r_cfg;
    w_value_nxt = r_value;
    w_data_nxt  = r_data;
    w_stop_nxt  = r_stop;
    w_clr       = 1'b0;
    if (w_count) begin
      if (w_term) begin
        if (r_cfg[CFG_CONT]) begin
          w_value_nxt = r_cfg[CFG_UP] ? '0 : r_data;
        end else begin
          w_stop_nxt = 1'b1;
        end
      end else if (r_cfg[CFG_UP]) begin
        w_value_nxt = r_value + ONE;
      end else begin
        w_value_nxt = r_value - ONE;
      end
    end else begin
      w_value_nxt = r_value;
    end
    if (i_we) begin
      case (reg_sel_e'(i_sel))
        REG_CFG:    w_cfg_nxt = i_wdata[CFG_BITS-1:0];
        REG_VALUE: begin
          w_value_nxt = i_wdata;
          w_stop_nxt  = 1'b0;
        end
        REG_DATA:   w_data_nxt = i_wdata;
        REG_STATUS: w_clr = i_wdata[STATUS_PEND];
        default:    w_clr = 1'b0;
      endcase
    end else begin
      w_clr = 1'b0;
    end
    if (!w_cfg_nxt[CFG_EN]) begin
      w_stop_nxt = 1'b0;
    end else begin
      w_stop_nxt = w_stop_nxt;
    end
    // A same-cycle event beats a software clear.
    w_pend_nxt = (w_fire & r_cfg[CFG_IRQ_EN]) ? 1'b1 : (w_clr ? 1'b0 : r_pend);
  end

  // Channel state registers with synchronous active-low reset.
  always_ff @(posedge clkin) begin
    if (!resetn) begin
      r_cfg   <= '0;
      r_value <= '0;
      r_data  <= '0;
      r_pend  <= 1'b0;
      r_stop  <= 1'b0;
      r_event <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_cfg   <= w_cfg_nxt;
      r_value <= w_value_nxt;
      r_data  <= w_data_nxt;
      r_pend  <= w_pend_nxt;
      r_stop  <= w_stop_nxt;
      r_event <= w_fire;
      r_irq   <= w_pend_nxt & w_cfg_nxt[CFG_IRQ_EN];
    end
  end

  assign o_cfg     = r_cfg;
  assign o_value   = r_value;
  assign o_data    = r_data;
  assign o_pending = r_pend;
  assign o_event   = r_event;
  assign o_irq     = r_irq;

endmodule

// File: rtl/counter_timer_multi.sv
// Multi-channel counter/timer top: address decode, registered read mux and
// event chaining between NCH counter_timer_chan instances.
module counter_timer_multi
  import counter_timer_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int WIDTH = 32
) (
  input  logic                        clkin,
  input  logic                        resetn,
  input  logic [addr_width(NCH)-1:0]  reg_addr,
  input  logic                        reg_we,
  input  logic [WIDTH-1:0]            reg_wdata,
  output logic [WIDTH-1:0]            reg_rdata,
  output logic [NCH-1:0]              event_out,
  output logic [NCH-1:0]              irq_out
);

  localparam int AW = addr_width(NCH);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [IW-1:0]       w_idx;
  logic [1:0]          w_sel;
  logic                w_hit;
  logic [CFG_BITS-1:0] w_cfg   [NCH];
  logic [WIDTH-1:0]    w_value [NCH];
  logic [WIDTH-1:0]    w_data  [NCH];
  logic [NCH-1:0]      w_pend;
  logic [NCH-1:0]      w_event;
  logic [NCH-1:0]      w_irq;
  logic [NCH-1:0]      w_prev;
  logic [WIDTH-1:0]    w_rd;
  logic [WIDTH-1:0]    r_rdata;

  if (NCH > 1) begin : g_idx
    assign w_idx = reg_addr[AW-1:2];
  end else begin : g_idx_one
    assign w_idx = '0;
  end

  assign w_sel = reg_addr[1:0];
  // Non-power-of-two NCH leaves unused channel indices; those are dead addresses.
  assign w_hit = (32'(w_idx) < 32'(NCH));

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    if (gi == 0) begin : g_first
      assign w_prev[gi] = 1'b0;
    end else begin : g_link
      assign w_prev[gi] = w_event[gi-1];
    end

    counter_timer_chan #(
      .WIDTH    (WIDTH),
      .CHAIN_OK (gi != 0)
    ) u_chan (
      .clkin        (clkin),
      .resetn       (resetn),
      .i_we         (reg_we & w_hit & (w_idx == IW'(gi))),
      .i_sel        (w_sel),
      .i_wdata      (reg_wdata),
      .i_prev_event (w_prev[gi]),
      .o_cfg        (w_cfg[gi]),
      .o_value      (w_value[gi]),
      .o_data       (w_data[gi]),
      .o_pending    (w_pend[gi]),
      .o_event      (w_event[gi]),
      .o_irq        (w_irq[gi])
    );
  end

  // Read mux over the addressed channel; dead addresses read as zero.
  always_comb begin
    w_rd = '0;
    if (w_hit) begin
      case (reg_sel_e'(w_sel))
        REG_CFG:    w_rd = {{(WIDTH-CFG_BITS){1'b0}}, w_cfg[w_idx]};
        REG_VALUE:  w_rd = w_value[w_idx];
        REG_DATA:   w_rd = w_data[w_idx];
        REG_STATUS: w_rd = {{(WIDTH-1){1'b0}}, w_pend[w_idx]};
        default:    w_rd = '0;
      endcase
    end else begin
      w_rd = '0;
    end
  end

  // Registered read data.
  always_ff @(posedge clkin) begin
    if (!resetn) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rd;
    end
  end

  assign reg_rdata = r_rdata;
  assign event_out = w_event;
  assign irq_out   = w_irq;

endmodule

// File: tb/tb_counter_timer_multi.sv
// Scoreboard bench for counter_timer_multi: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares rdata/event_out/irq_out.
module tb_counter_timer_multi;

  localparam int NCH = 3;
  localparam int W   = 32;
  localparam int AW  = 4;

  logic           clkin = 1'b0;
  logic           resetn;
  logic [AW-1:0]  reg_addr;
  logic           reg_we;
  logic [W-1:0]   reg_wdata;
  logic [W-1:0]   reg_rdata;
  logic [NCH-1:0] event_out;
  logic [NCH-1:0] irq_out;

  logic chk_req;
  logic chk_v;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [W-1:0]   q_rd  [$];
  logic [NCH-1:0] q_ev  [$];
  logic [NCH-1:0] q_irq [$];
  string          q_nm  [$];

  always #5 clkin = ~clkin;

  counter_timer_multi #(.NCH(NCH), .WIDTH(W)) dut (
    .clkin     (clkin),
    .resetn    (resetn),
    .reg_addr  (reg_addr),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .event_out (event_out),
    .irq_out   (irq_out)
  );

  // Marks the cycle whose outputs carry a queued expectation.
  always_ff @(posedge clkin) chk_v <= chk_req;

  task automatic compare(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pop one expectation per flagged cycle, away from the active edge.
  always @(negedge clkin) begin
    if (chk_v === 1'b1) begin
      if (q_rd.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
      end else begin
        logic [W-1:0]   e_rd;
        logic [NCH-1:0] e_ev;
        logic [NCH-1:0] e_irq;
        string          nm;
        e_rd  = q_rd.pop_front();
        e_ev  = q_ev.pop_front();
        e_irq = q_irq.pop_front();
        nm    = q_nm.pop_front();
        compare({nm, ".rdata"}, reg_rdata, e_rd);
        compare({nm, ".event"}, W'(event_out), W'(e_ev));
        compare({nm, ".irq"},   W'(irq_out),   W'(e_irq));
      end
    end
  end

  task automatic cyc(input logic we, input logic [AW-1:0] a, input logic [W-1:0] d,
                     input logic chk, input logic [W-1:0] erd, input logic [NCH-1:0] eev,
                     input logic [NCH-1:0] eirq, input string nm);
    reg_we    = we;
    reg_addr  = a;
    reg_wdata = d;
    chk_req   = chk;
    if (chk) begin
      q_rd.push_back(erd);
      q_ev.push_back(eev);
      q_irq.push_back(eirq);
      q_nm.push_back(nm);
    end
    @(posedge clkin);
    #1;
    reg_we  = 1'b0;
    chk_req = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    cyc(1'b1, a, d, 1'b0, 32'h0, 3'b000, 3'b000, "");
  endtask

  task automatic nop();
    cyc(1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 3'b000, 3'b000, "");
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] erd,
                    input logic [NCH-1:0] eev, input logic [NCH-1:0] eirq, input string nm);
    cyc(1'b0, a, 32'h0, 1'b1, erd, eev, eirq, nm);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn    = 1'b0;
    reg_we    = 1'b0;
    reg_addr  = 4'd0;
    reg_wdata = 32'h0;
    chk_req   = 1'b0;

    // Reset state
    rd(4'd0, 32'h0, 3'b000, 3'b000, "rst_hold0");
    rd(4'd1, 32'h0, 3'b000, 3'b000, "rst_hold1");
    resetn = 1'b1;
    rd(4'd0, 32'h0, 3'b000, 3'b000, "rst_cfg0");
    rd(4'd1, 32'h0, 3'b000, 3'b000, "rst_value0");

    // Ch0 down one-shot irq, VALUE=5: event 6 cycles after enable
    wr(4'd1, 32'd5);
    wr(4'd0, 32'h11);
    rd(4'd1, 32'd5, 3'b000, 3'b000, "os_v5");
    rd(4'd1, 32'd4, 3'b000, 3'b000, "os_v4");
    rd(4'd1, 32'd3, 3'b000, 3'b000, "os_v3");
    rd(4'd1, 32'd2, 3'b000, 3'b000, "os_v2");
    rd(4'd1, 32'd1, 3'b000, 3'b000, "os_v1");
    rd(4'd1, 32'd0, 3'b001, 3'b001, "os_fire");
    rd(4'd1, 32'd0, 3'b000, 3'b001, "os_after");
    rd(4'd3, 32'd1, 3'b000, 3'b001, "os_status");
    wr(4'd3, 32'd1);
    rd(4'd3, 32'd0, 3'b000, 3'b000, "os_cleared");
    rd(4'd1, 32'd0, 3'b000, 3'b000, "os_hold0");
    wr(4'd0, 32'h0);

    // Ch0 up continuous DATA=3 VALUE=0: 0,1,2,3,0 with event every 4 cycles
    wr(4'd2, 32'd3);
    wr(4'd1, 32'd0);
    wr(4'd0, 32'h07);
    rd(4'd1, 32'd0, 3'b000, 3'b000, "up_0");
    rd(4'd1, 32'd1, 3'b000, 3'b000, "up_1");
    rd(4'd1, 32'd2, 3'b000, 3'b000, "up_2");
    rd(4'd1, 32'd3, 3'b001, 3'b000, "up_3");
    rd(4'd1, 32'd0, 3'b000, 3'b000, "up_wrap0");
    rd(4'd1, 32'd1, 3'b000, 3'b000, "up_wrap1");
    rd(4'd1, 32'd2, 3'b000, 3'b000, "up_wrap2");
    rd(4'd1, 32'd3, 3'b001, 3'b000, "up_wrap3");
    rd(4'd0, 32'h07, 3'b000, 3'b000, "up_cfg");
    wr(4'd0, 32'h0);

    // Chain: ch0 down continuous DATA=2, ch1 chained down one-shot VALUE=1
    wr(4'd2, 32'd2);
    wr(4'd1, 32'd2);
    wr(4'd5, 32'd1);
    wr(4'd4, 32'h09);
    wr(4'd0, 32'h03);
    rd(4'd5, 32'd1, 3'b000, 3'b000, "ch_c6");
    rd(4'd5, 32'd1, 3'b000, 3'b000, "ch_c7");
    rd(4'd5, 32'd1, 3'b001, 3'b000, "ch_ev0a");
    rd(4'd5, 32'd1, 3'b000, 3'b000, "ch_c9");
    rd(4'd5, 32'd0, 3'b000, 3'b000, "ch_c10");
    rd(4'd5, 32'd0, 3'b001, 3'b000, "ch_ev0b");
    rd(4'd5, 32'd0, 3'b010, 3'b000, "ch_ev1");
    rd(4'd5, 32'd0, 3'b000, 3'b000, "ch_c13");
    rd(4'd7, 32'd0, 3'b001, 3'b000, "ch_status1");
    rd(4'd5, 32'd0, 3'b000, 3'b000, "ch_stopped");
    wr(4'd0, 32'h0);
    wr(4'd4, 32'h0);

    // VALUE write on a counting cycle wins; DATA write leaves VALUE alone
    wr(4'd2, 32'h100);
    wr(4'd1, 32'h5000);
    wr(4'd0, 32'h03);
    nop();
    wr(4'd1, 32'h12bc);
    rd(4'd1, 32'h12bc, 3'b000, 3'b000, "vw_first");
    rd(4'd1, 32'h12bb, 3'b000, 3'b000, "vw_dec");
    wr(4'd2, 32'h7);
    rd(4'd1, 32'h12b9, 3'b000, 3'b000, "dw_value");
    rd(4'd2, 32'h7, 3'b000, 3'b000, "dw_data");
    wr(4'd0, 32'h0);

    // STATUS clear on the same cycle as an event: set wins
    wr(4'd1, 32'd1);
    wr(4'd0, 32'h11);
    nop();
    cyc(1'b1, 4'd3, 32'd1, 1'b1, 32'd0, 3'b001, 3'b001, "clr_vs_set");
    rd(4'd3, 32'd1, 3'b000, 3'b001, "clr_vs_set_st");
    wr(4'd3, 32'd1);
    rd(4'd3, 32'd0, 3'b000, 3'b000, "clr_after");
    wr(4'd0, 32'h0);

    // Unimplemented channel index 3
    wr(4'd13, 32'hffff);
    rd(4'd13, 32'd0, 3'b000, 3'b000, "bad_value");
    rd(4'd12, 32'd0, 3'b000, 3'b000, "bad_cfg");
    rd(4'd9,  32'd0, 3'b000, 3'b000, "bad_alias_ch2");

    // Reset mid-count
    wr(4'd6, 32'h55);
    wr(4'd2, 32'h0);
    wr(4'd1, 32'hdcba7cfb);
    wr(4'd0, 32'h13);
    nop();
    nop();
    nop();
    rd(4'd1, 32'hdcba7cf8, 3'b000, 3'b000, "mid_count");
    resetn = 1'b0;
    rd(4'd1, 32'd0, 3'b000, 3'b000, "mid_rst0");
    rd(4'd1, 32'd0, 3'b000, 3'b000, "mid_rst1");
    resetn = 1'b1;
    rd(4'd0, 32'd0, 3'b000, 3'b000, "post_cfg0");
    rd(4'd1, 32'd0, 3'b000, 3'b000, "post_value0");
    rd(4'd2, 32'd0, 3'b000, 3'b000, "post_data0");
    rd(4'd3, 32'd0, 3'b000, 3'b000, "post_status0");
    rd(4'd6, 32'd0, 3'b000, 3'b000, "post_data1");
    nop();
    nop();
    nop();
    rd(4'd1, 32'd0, 3'b000, 3'b000, "post_idle");

    nop();
    nop();
    compare("queue_drained", W'(q_rd.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
